// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch (if_*), data (dm_*) and memory (mem_*) handshakes of the
//   shared memory port, plus the hazard-unit stall flags and the watchdog error.
//   slave  : arbiter view (requests and memory responses in, results out)
//   master : environment view (core stages and memory model)
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Fetch stage
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    // Memory stage
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    // Memory
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    // Hazard unit / status
    logic              stall_if;
    logic              stall_dm;
    logic              timeout_err;

    modport slave (
        input  if_req, if_addr, if_kill,
        output if_rdata, if_ready,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output stall_if, stall_dm, timeout_err
    );

    modport master (
        output if_req, if_addr, if_kill,
        input  if_rdata, if_ready,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  stall_if, stall_dm, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the fetch stage (IF) and the memory
//   stage (DM). Round-robin arbitration on conflict, one access in flight at a
//   time, an 8-bit watchdog per access, and IF kill that drops an access result.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (IF/DM requesters, memory, stalls, error)
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  reset,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyDm} arbState_t;

    // Watchdog fires when the count would step onto TIMEOUT.
    localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

    arbState_t         state;
    logic              lastGrantDm;
    logic              discard;
    logic [7:0]        wdCnt;
    logic              timeoutErr;
    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              ifReady;
    logic              dmReady;
    logic [DATA_W-1:0] ifRdata;
    logic [DATA_W-1:0] dmRdata;

    logic              ifElig;
    logic              dmElig;
    logic              grantDm;
    logic              finish;
    logic              ifDrop;
    logic [DATA_W-1:0] respData;

    assign ifElig   = bus.if_req & ~ifReady & ~bus.if_kill;
    assign dmElig   = bus.dm_req & ~dmReady;
    // On conflict the side not granted last wins.
    assign grantDm  = dmElig & (~ifElig | ~lastGrantDm);
    // Ack takes priority over the watchdog; an expired access returns zero.
    assign finish   = bus.mem_ack | (wdCnt == WdLast);
    assign respData = bus.mem_ack ? bus.mem_rdata : '0;
    // A kill in the completing cycle still suppresses the result.
    assign ifDrop   = discard | bus.if_kill;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            lastGrantDm <= 1'b0;
            discard     <= 1'b0;
            wdCnt       <= '0;
            timeoutErr  <= 1'b0;
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWdata    <= '0;
            ifReady     <= 1'b0;
            dmReady     <= 1'b0;
            ifRdata     <= '0;
            dmRdata     <= '0;
        end else begin
            ifReady <= 1'b0;
            dmReady <= 1'b0;
            case (state)
                StIdle: begin
                    discard <= 1'b0;
                    if (grantDm) begin
                        state       <= StBusyDm;
                        memReq      <= 1'b1;
                        memWe       <= bus.dm_we;
                        memAddr     <= bus.dm_addr;
                        memWdata    <= bus.dm_wdata;
                        lastGrantDm <= 1'b1;
                        wdCnt       <= '0;
                    end else if (ifElig) begin
                        state       <= StBusyIf;
                        memReq      <= 1'b1;
                        memWe       <= 1'b0;
                        memAddr     <= bus.if_addr;
                        lastGrantDm <= 1'b0;
                        wdCnt       <= '0;
                    end
                end
                StBusyIf, StBusyDm: begin
                    if (finish) begin
                        state   <= StIdle;
                        memReq  <= 1'b0;
                        discard <= 1'b0;
                        if (!bus.mem_ack) begin
                            timeoutErr <= 1'b1;
                        end
                        if (state == StBusyIf) begin
                            if (!ifDrop) begin
                                ifRdata <= respData;
                                ifReady <= 1'b1;
                            end
                        end else begin
                            // An acked store leaves the load data register alone.
                            if (!(memWe && bus.mem_ack)) begin
                                dmRdata <= respData;
                            end
                            dmReady <= 1'b1;
                        end
                    end else begin
                        wdCnt <= wdCnt + 8'd1;
                        if (state == StBusyIf && bus.if_kill) begin
                            discard <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.mem_req     = memReq;
    assign bus.mem_we      = memWe;
    assign bus.mem_addr    = memAddr;
    assign bus.mem_wdata   = memWdata;
    assign bus.if_ready    = ifReady;
    assign bus.if_rdata    = ifRdata;
    assign bus.dm_ready    = dmReady;
    assign bus.dm_rdata    = dmRdata;
    assign bus.timeout_err = timeoutErr;
    assign bus.stall_if    = bus.if_req & ~ifReady;
    assign bus.stall_dm    = bus.dm_req & ~dmReady;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Random IF/DM requesters, kills and a randomly acking memory drive the
//   arbiter; a transaction-level reference model (one in-flight access record,
//   round-robin winner, sticky error) predicts every output each cycle.
module tb_mem_port_arbiter;

    localparam int unsigned TIMEOUT = 4;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Stimulus state
    bit          ifActive, dmActive;
    logic        ifReq, ifKill, dmReq, dmWe, memAck;
    logic [31:0] ifAddr, dmAddr, dmWdata, memRdata;
    int unsigned ackPct;

    // Reference model
    typedef struct {
        bit          valid;
        bit          isIf;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        int unsigned age;
        bit          dropped;
    } access_t;

    access_t     acc;
    bit          expIfReady, expDmReady, expErr, lastWasIf;
    logic [31:0] expIfRdata, expDmRdata;

    task automatic modelReset();
        acc.valid  = 1'b0;
        expIfReady = 1'b0;
        expDmReady = 1'b0;
        expIfRdata = '0;
        expDmRdata = '0;
        expErr     = 1'b0;
        lastWasIf  = 1'b1;
    endtask

    // Advance the model across one rising edge using the inputs of the ending cycle.
    task automatic modelStep();
        bit          done;
        bit          drop;
        bit          ifWants, dmWants, pickDm;
        bit          newIfReady, newDmReady;
        logic [31:0] data;
        newIfReady = 1'b0;
        newDmReady = 1'b0;
        done       = 1'b0;
        data       = '0;
        if (acc.valid) begin
            if (memAck) begin
                done = 1'b1;
                data = memRdata;
            end else if (acc.age + 1 == TIMEOUT) begin
                done   = 1'b1;
                data   = '0;
                expErr = 1'b1;
            end else begin
                acc.age++;
                if (acc.isIf && ifKill) acc.dropped = 1'b1;
            end
            if (done) begin
                drop = acc.dropped || (acc.isIf && ifKill);
                if (acc.isIf) begin
                    if (!drop) begin
                        expIfRdata = data;
                        newIfReady = 1'b1;
                    end
                end else begin
                    if (!(acc.we && memAck)) expDmRdata = data;
                    newDmReady = 1'b1;
                end
                acc.valid = 1'b0;
            end
        end else begin
            ifWants = ifReq && !expIfReady && !ifKill;
            dmWants = dmReq && !expDmReady;
            if (ifWants || dmWants) begin
                pickDm      = dmWants && (!ifWants || lastWasIf);
                acc.valid   = 1'b1;
                acc.isIf    = !pickDm;
                acc.addr    = pickDm ? dmAddr : ifAddr;
                acc.we      = pickDm ? dmWe : 1'b0;
                acc.wdata   = dmWdata;
                acc.age     = 0;
                acc.dropped = 1'b0;
                lastWasIf   = !pickDm;
            end
        end
        expIfReady = newIfReady;
        expDmReady = newDmReady;
    endtask

    task automatic applyInputs();
        bus.if_req    = ifReq;
        bus.if_addr   = ifAddr;
        bus.if_kill   = ifKill;
        bus.dm_req    = dmReq;
        bus.dm_we     = dmWe;
        bus.dm_addr   = dmAddr;
        bus.dm_wdata  = dmWdata;
        bus.mem_ack   = memAck;
        bus.mem_rdata = memRdata;
    endtask

    task automatic checkOutputs();
        checkEq("mem_req", 32'(bus.mem_req), 32'(acc.valid));
        if (acc.valid) begin
            checkEq("mem_we", 32'(bus.mem_we), 32'(acc.we));
            checkEq("mem_addr", bus.mem_addr, acc.addr);
            if (!acc.isIf) checkEq("mem_wdata", bus.mem_wdata, acc.wdata);
        end
        checkEq("if_ready", 32'(bus.if_ready), 32'(expIfReady));
        checkEq("dm_ready", 32'(bus.dm_ready), 32'(expDmReady));
        checkEq("if_rdata", bus.if_rdata, expIfRdata);
        checkEq("dm_rdata", bus.dm_rdata, expDmRdata);
        checkEq("stall_if", 32'(bus.stall_if), 32'(ifReq & ~expIfReady));
        checkEq("stall_dm", 32'(bus.stall_dm), 32'(dmReq & ~expDmReady));
        checkEq("timeout_err", 32'(bus.timeout_err), 32'(expErr));
    endtask

    task automatic checkResetValues(input string tag);
        checkEq({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        checkEq({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        checkEq({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        checkEq({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        checkEq({tag, "_if_ready"}, 32'(bus.if_ready), 32'd0);
        checkEq({tag, "_dm_ready"}, 32'(bus.dm_ready), 32'd0);
        checkEq({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        checkEq({tag, "_dm_rdata"}, bus.dm_rdata, 32'd0);
        checkEq({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
    endtask

    initial begin
        bit prevIfReady, prevDmReady, prevKill, wantReset;
        int resetsDone;
        ifActive = 1'b0;  dmActive = 1'b0;
        ifReq = 1'b0;     ifKill = 1'b0;   ifAddr = '0;
        dmReq = 1'b0;     dmWe = 1'b0;     dmAddr = '0;   dmWdata = '0;
        memAck = 1'b0;    memRdata = '0;
        wantReset  = 1'b0;
        resetsDone = 0;
        applyInputs();
        modelReset();
        reset = 1'b0;
        #12;
        checkResetValues("por");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            prevIfReady = expIfReady;
            prevDmReady = expDmReady;
            prevKill    = ifKill;
            modelStep();
            #1;
            // Requests are held through their ready (or kill) cycle, then dropped.
            if (prevIfReady || prevKill) ifActive = 1'b0;
            if (prevDmReady) dmActive = 1'b0;
            if (!ifActive && $urandom_range(99) < 50) begin
                ifActive = 1'b1;
                ifAddr   = $urandom;
            end
            if (!dmActive && $urandom_range(99) < 40) begin
                dmActive = 1'b1;
                dmWe     = 1'($urandom_range(1));
                dmAddr   = $urandom;
                dmWdata  = $urandom;
            end
            ifReq  = ifActive;
            dmReq  = dmActive;
            ifKill = ($urandom_range(99) < 7);
            ackPct = ((i / 300) % 4 == 3) ? 0 : (((i / 300) % 2 == 1) ? 80 : 35);
            memAck   = ($urandom_range(99) < ackPct);
            memRdata = $urandom;
            applyInputs();

            if (i % 600 == 300) wantReset = 1'b1;
            if (wantReset && acc.valid && !acc.isIf && resetsDone < 5) begin
                // Reset mid-access, well away from any clock edge.
                wantReset = 1'b0;
                resetsDone++;
                #1;
                reset = 1'b0;
                #1;
                checkResetValues("async_rst");
                modelReset();
                // Both sides request on release: the first conflict must go to DM.
                ifActive = 1'b1;  dmActive = 1'b1;
                ifReq = 1'b1;     dmReq = 1'b1;   ifKill = 1'b0;
                ifAddr = $urandom;
                dmWe = 1'b0;      dmAddr = $urandom;  dmWdata = $urandom;
                applyInputs();
                @(negedge clk);
                reset = 1'b1;
            end else begin
                @(negedge clk);
            end
            checkOutputs();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported instruction/data memory between the fetch stage (IF) and the memory stage (DM) of the pipelined MCU core. Requests are arbitrated and issued to memory over a req/ack handshake, with a watchdog on each access. Results are returned to the requester, and stall flags go to the hazard unit, which ORs them into its fetch and memory-stage stalls. An IF access in flight can be killed by a pipeline flush; the memory access still completes but its result is dropped.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 15, cycles to wait for mem_ack before aborting an access (1..255)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ready or if_kill
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  flush of fetch stage (PCSrcW/BranchTaken/FlushD); discards pending/in-flight IF access
- if_rdata  out  DATA_W  fetched word, registered
- if_ready  out  1  one-cycle pulse: if_rdata valid
- dm_req  in  1  data request; held until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered
- dm_ready  out  1  one-cycle pulse: access complete
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write enable, stable while mem_req
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only while mem_req=1
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_dm  out  1  dm_req & ~dm_ready (combinational)
- timeout_err  out  1  sticky: set on any watchdog expiry, cleared only by reset

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE arbitration, per cycle:
  - A requester is eligible if its req=1 and its ready output is 0 this cycle.
  - IF is also ineligible when if_kill=1.
  - Both eligible: the side not granted last wins; last_grant resets to IF, so DM wins the first conflict.
  - One eligible: grant it.
  - Grant: latch addr/we/wdata (IF forces we=0), set mem_req, update last_grant, go to BUSY_x.
- BUSY_x: mem_* outputs are frozen. On mem_ack=1 at an edge:
  - Clear mem_req and go to IDLE.
  - Register mem_rdata into x_rdata (DM store: dm_rdata keeps its old value).
  - Pulse x_ready for one cycle, unless the access is marked discarded.
- Kill: if_kill=1 in any cycle of BUSY_IF sets the discard flag. The access completes normally, but no if_ready pulse is given and if_rdata is unchanged. The discard flag clears on the return to IDLE.
- Watchdog:
  - An 8-bit counter clears on grant and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT without ack: drop mem_req, go to IDLE, set timeout_err.
  - The requester gets a ready pulse with rdata = 0 (if not discarded), so the core never hangs.
- mem_ack in IDLE is ignored.

## Timing
- Reset values:
  - state=IDLE, last_grant=IF, discard=0, counter=0, timeout_err=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ready=0, dm_ready=0, if_rdata=0, dm_rdata=0.
- Reset asserted mid-access: mem_req drops immediately (asynchronously); the access is lost.
- Latency for an uncontended request with req high in cycle 0:
  - Grant at edge 1; mem_req=1 in cycle 1.
  - If mem_ack=1 in cycle 1, x_ready=1 in cycle 2.
  - Total is 2 + (memory wait cycles).
- Back-to-back: a ready cycle is an IDLE cycle in which the other side may be granted. The same side can be re-granted no earlier than the cycle after its ready pulse.
- mem_ack and the timeout in the same cycle: the ack wins and no error is flagged.
- if_kill in the same cycle as mem_ack in BUSY_IF: the ready pulse is suppressed.
- stall_if and stall_dm are combinational from req/ready; no additional latency.

## Test plan
- Single load: dm_req, dm_addr=0x40, memory acks after 2 wait cycles with 0xDEADBEEF -> mem_req high cycles 1–3, dm_ready pulse in cycle 4, dm_rdata=0xDEADBEEF, stall_dm=1 in cycles 0–3.
- Contention: if_req and dm_req together from reset, 0-wait memory -> DM granted first, IF second; alternation continues while both stay requested; mem_we=0 on IF grant.
- Store: dm_we=1, dm_wdata=0x12345678 -> mem_we=1 with stable data until ack; dm_ready pulses; dm_rdata unchanged.
- Kill in flight: IF granted, if_kill pulsed in its second BUSY cycle, ack with 0xAAAA5555 -> no if_ready, if_rdata unchanged; next if_req granted normally.
- Timeout with TIMEOUT=4: memory never acks -> mem_req drops after 4 BUSY cycles, ready pulse with rdata=0, timeout_err=1 held until reset.
- Async reset mid BUSY_DM -> all outputs return to reset values without a clock edge; the first post-reset conflict goes to DM.
